// File: rtl/incubator_pkg.sv
// Shared types and constants for the incubator heater arbiter and the zone controllers.
// Zone FSM encoding, default MIN_ON/SLICE timing and a popcount helper.
package incubator_pkg;

    typedef enum logic [1:0] {
        ZS_IDLE = 2'd0,
        ZS_WAIT = 2'd1,
        ZS_ON   = 2'd2
    } zone_state_t;

    localparam int DEF_MIN_ON = 4;
    localparam int DEF_SLICE  = 16;

    // Sized for the largest supported zone count (8).
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/incubator_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping mod N.
// Purely combinational; pick is one-hot, valid flags that something was chosen.
module incubator_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);

    always_comb begin
        int idx;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && eligible[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/incubator_heater_arbiter.sv
// Shares a limited heater supply between zones: at most MAX_ACTIVE grants, one new grant
// per cycle, MIN_ON hold time and SLICE time-slicing. Define INCUBATOR_ARB_STARVE_EN for starve flags.
module incubator_heater_arbiter
    import incubator_pkg::*;
#(
    parameter int NZONES     = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int MIN_ON     = DEF_MIN_ON,
    parameter int SLICE      = DEF_SLICE,
    parameter int CW         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NZONES-1:0] heat_req,
    output logic [NZONES-1:0] heat_gnt,
    output logic [3:0]        active_cnt,
    output logic              full
`ifdef INCUBATOR_ARB_STARVE_EN
    ,
    output logic [NZONES-1:0] starve
`endif
);

    localparam int PW = (NZONES > 1) ? $clog2(NZONES) : 1;

    zone_state_t       zone_state     [NZONES];
    zone_state_t       zone_state_nxt [NZONES];
    logic [CW-1:0]     on_cnt         [NZONES];
    logic [CW-1:0]     on_cnt_nxt     [NZONES];
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_ptr_nxt;
    logic [NZONES-1:0] eligible;
    logic [NZONES-1:0] waiting;
    logic [NZONES-1:0] pick;
    logic [NZONES-1:0] gnt_nxt;
    logic [3:0]        cnt_nxt;
    logic              pick_valid;
    logic              slot_free;

    // The registered count gates new grants, so a slot freed this edge is reused one cycle later.
    assign slot_free = enable && (active_cnt < 4'(MAX_ACTIVE));

    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            eligible[i] = slot_free && heat_req[i] && (zone_state[i] != ZS_ON);
            waiting[i]  = (zone_state[i] == ZS_WAIT);
        end
    end

    incubator_rr_pick #(
        .N  (NZONES),
        .PW (PW)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .pick     (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        logic [NZONES-1:0] others;
        rr_ptr_nxt = rr_ptr;
        others     = '0;
        for (int i = 0; i < NZONES; i++) begin
            zone_state_nxt[i] = zone_state[i];
            on_cnt_nxt[i]     = on_cnt[i];
            others            = waiting;
            others[i]         = 1'b0;
            if (!enable) begin
                // Safety drop: MIN_ON is deliberately not honoured here.
                zone_state_nxt[i] = heat_req[i] ? ZS_WAIT : ZS_IDLE;
                on_cnt_nxt[i]     = '0;
            end else begin
                case (zone_state[i])
                    ZS_IDLE, ZS_WAIT: begin
                        if (pick[i]) begin
                            zone_state_nxt[i] = ZS_ON;
                            on_cnt_nxt[i]     = '0;
                        end else begin
                            zone_state_nxt[i] = heat_req[i] ? ZS_WAIT : ZS_IDLE;
                        end
                    end
                    ZS_ON: begin
                        if (!heat_req[i] && (int'(on_cnt[i]) >= MIN_ON - 1)) begin
                            zone_state_nxt[i] = ZS_IDLE;
                            on_cnt_nxt[i]     = '0;
                        end else if (heat_req[i] && (int'(on_cnt[i]) >= SLICE - 1) && (|others)) begin
                            zone_state_nxt[i] = ZS_WAIT;
                            on_cnt_nxt[i]     = '0;
                        end else if (int'(on_cnt[i]) < SLICE) begin
                            on_cnt_nxt[i] = on_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        zone_state_nxt[i] = ZS_IDLE;
                        on_cnt_nxt[i]     = '0;
                    end
                endcase
            end
            gnt_nxt[i] = (zone_state_nxt[i] == ZS_ON);
            if (pick[i] && pick_valid) begin
                rr_ptr_nxt = (i == NZONES - 1) ? '0 : PW'(i + 1);
            end
        end
        cnt_nxt = popcount(8'(gnt_nxt));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NZONES; i++) begin
                zone_state[i] <= ZS_IDLE;
                on_cnt[i]     <= '0;
            end
            rr_ptr     <= '0;
            heat_gnt   <= '0;
            active_cnt <= '0;
            full       <= 1'b0;
        end else begin
            for (int i = 0; i < NZONES; i++) begin
                zone_state[i] <= zone_state_nxt[i];
                on_cnt[i]     <= on_cnt_nxt[i];
            end
            rr_ptr     <= rr_ptr_nxt;
            heat_gnt   <= gnt_nxt;
            active_cnt <= cnt_nxt;
            full       <= (cnt_nxt == 4'(MAX_ACTIVE));
        end
    end

`ifdef INCUBATOR_ARB_STARVE_EN
    localparam int STARVE_LIM = 4 * SLICE;
    localparam int WW         = $clog2(STARVE_LIM + 1);

    logic [WW-1:0]     wait_cnt     [NZONES];
    logic [WW-1:0]     wait_cnt_nxt [NZONES];
    logic [NZONES-1:0] starve_nxt;

    // Counts consecutive WAIT cycles, saturating at the starvation limit.
    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            wait_cnt_nxt[i] = '0;
            if (zone_state_nxt[i] == ZS_WAIT) begin
                wait_cnt_nxt[i] = (int'(wait_cnt[i]) < STARVE_LIM) ? wait_cnt[i] + 1'b1 : wait_cnt[i];
            end
            starve_nxt[i] = (int'(wait_cnt_nxt[i]) >= STARVE_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NZONES; i++) begin
                wait_cnt[i] <= '0;
            end
            starve <= '0;
        end else begin
            for (int i = 0; i < NZONES; i++) begin
                wait_cnt[i] <= wait_cnt_nxt[i];
            end
            starve <= starve_nxt;
        end
    end
`endif

endmodule
